// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment driver paced by rising edges of a slow scan square wave.
// Define SEG_SCAN_LZB_EN to blank leading zero digits (digit 0 is always lit).
module seven_seg_scanner #(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        scanClk,
   input  logic        enable,
   input  logic [15:0] value,
   input  logic [3:0]  dp,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dpOut,
   output logic [1:0]  digitIdx
);

   localparam logic [3:0] AN_MASK  = ACTIVE_LOW ? 4'hF  : 4'h0;
   localparam logic [6:0] SEG_MASK = ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic       DP_MASK  = ACTIVE_LOW;

   logic        r_scanPrev;
   logic [1:0]  r_idx;
   logic [15:0] r_snap;
   logic [3:0]  r_snapDp;
   logic [3:0]  r_an;
   logic [6:0]  r_seg;
   logic        r_dp;

   logic        w_tick;
   logic        w_advance;
   logic [1:0]  w_nextIdx;
   logic [15:0] w_nextSnap;
   logic [3:0]  w_nextSnapDp;
   logic [3:0]  w_digit;
   logic        w_lzBlank;
   logic [3:0]  w_anNext;
   logic [6:0]  w_segNext;
   logic        w_dpNext;

   function automatic logic [6:0] hexDecode(input logic [3:0] n);
      case (n)
         4'h0: hexDecode = 7'b0111111;
         4'h1: hexDecode = 7'b0000110;
         4'h2: hexDecode = 7'b1011011;
         4'h3: hexDecode = 7'b1001111;
         4'h4: hexDecode = 7'b1100110;
         4'h5: hexDecode = 7'b1101101;
         4'h6: hexDecode = 7'b1111101;
         4'h7: hexDecode = 7'b0000111;
         4'h8: hexDecode = 7'b1111111;
         4'h9: hexDecode = 7'b1101111;
         4'hA: hexDecode = 7'b1110111;
         4'hB: hexDecode = 7'b1111100;
         4'hC: hexDecode = 7'b0111001;
         4'hD: hexDecode = 7'b1011110;
         4'hE: hexDecode = 7'b1111001;
         default: hexDecode = 7'b1110001;
      endcase
   endfunction

   assign w_tick       = scanClk & ~r_scanPrev;
   assign w_advance    = w_tick & enable;
   assign w_nextIdx    = r_idx + 2'd1;
   // The wrap from digit 3 to digit 0 is the only point a new snapshot is taken.
   assign w_nextSnap   = (r_idx == 2'd3) ? value : r_snap;
   assign w_nextSnapDp = (r_idx == 2'd3) ? dp    : r_snapDp;

   always_comb begin
      w_digit = w_nextSnap[3:0];
      case (w_nextIdx)
         2'd1:    w_digit = w_nextSnap[7:4];
         2'd2:    w_digit = w_nextSnap[11:8];
         2'd3:    w_digit = w_nextSnap[15:12];
         default: w_digit = w_nextSnap[3:0];
      endcase
   end

`ifdef SEG_SCAN_LZB_EN
   always_comb begin
      w_lzBlank = 1'b0;
      case (w_nextIdx)
         2'd3:    w_lzBlank = (w_nextSnap[15:12] == 4'h0);
         2'd2:    w_lzBlank = (w_nextSnap[15:8]  == 8'h00);
         2'd1:    w_lzBlank = (w_nextSnap[15:4]  == 12'h000);
         default: w_lzBlank = 1'b0;
      endcase
   end
`else
   assign w_lzBlank = 1'b0;
`endif

   // Build the next digit in active-high form, then apply the polarity mask once.
   assign w_anNext  = (w_lzBlank ? 4'h0  : (4'b0001 << w_nextIdx)) ^ AN_MASK;
   assign w_segNext = (w_lzBlank ? 7'h00 : hexDecode(w_digit))     ^ SEG_MASK;
   assign w_dpNext  = (w_lzBlank ? 1'b0  : w_nextSnapDp[w_nextIdx]) ^ DP_MASK;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_scanPrev <= 1'b0;
         r_idx      <= 2'd3;
         r_snap     <= 16'h0000;
         r_snapDp   <= 4'h0;
         r_an       <= AN_MASK;
         r_seg      <= SEG_MASK;
         r_dp       <= DP_MASK;
      end else begin
         r_scanPrev <= scanClk;
         if (!enable) begin
            r_an  <= AN_MASK;
            r_seg <= SEG_MASK;
            r_dp  <= DP_MASK;
         end else if (w_advance) begin
            r_idx    <= w_nextIdx;
            r_snap   <= w_nextSnap;
            r_snapDp <= w_nextSnapDp;
            r_an     <= w_anNext;
            r_seg    <= w_segNext;
            r_dp     <= w_dpNext;
         end
      end
   end

   assign an       = r_an;
   assign seg      = r_seg;
   assign dpOut    = r_dp;
   assign digitIdx = r_idx;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (ACTIVE_LOW = 1): vector table plus corner-case sequences.
module tb_seven_seg_scanner;

   logic        clk = 1'b0;
   logic        reset;
   logic        scanClk;
   logic        enable;
   logic [15:0] value;
   logic [3:0]  dp;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dpOut;
   logic [1:0]  digitIdx;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string      name;
      logic [1:0] idx;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dpo;
   } expT;

   typedef struct {
      logic [15:0] value;
      logic [3:0]  dp;
      logic [1:0]  idx;
      logic [3:0]  an;
      logic [6:0]  seg;
      logic        dpo;
   } vecT;

   expT sbQ[$];
   vecT vecs[17];

   seven_seg_scanner #(.ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .reset(reset), .scanClk(scanClk), .enable(enable),
      .value(value), .dp(dp), .an(an), .seg(seg), .dpOut(dpOut), .digitIdx(digitIdx)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic pushExp(input string nm, input logic [1:0] i, input logic [3:0] a,
                          input logic [6:0] s, input logic d);
      expT e;
      e.name = nm; e.idx = i; e.an = a; e.seg = s; e.dpo = d;
      sbQ.push_back(e);
   endtask

   task automatic checkOutput();
      expT e;
      if (sbQ.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL scoreboard: empty queue at time %0t", $time);
      end else begin
         e = sbQ.pop_front();
         cmp({e.name, ".digitIdx"}, {14'd0, digitIdx}, {14'd0, e.idx});
         cmp({e.name, ".an"},       {12'd0, an},       {12'd0, e.an});
         cmp({e.name, ".seg"},      {9'd0, seg},       {9'd0, e.seg});
         cmp({e.name, ".dpOut"},    {15'd0, dpOut},    {15'd0, e.dpo});
      end
   endtask

   task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d,
                                input logic s, input logic en);
      @(negedge clk);
      value   = v;
      dp      = d;
      scanClk = s;
      enable  = en;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{16'h1234, 4'h2, 2'd0, 4'hE, 7'b0011001, 1'b1};
      vecs[1]  = '{16'h1234, 4'h2, 2'd1, 4'hD, 7'b0110000, 1'b0};
      vecs[2]  = '{16'h1234, 4'h2, 2'd2, 4'hB, 7'b0100100, 1'b1};
      vecs[3]  = '{16'h1234, 4'h2, 2'd3, 4'h7, 7'b1111001, 1'b1};
      vecs[4]  = '{16'h1234, 4'h2, 2'd0, 4'hE, 7'b0011001, 1'b1};
      vecs[5]  = '{16'hABCD, 4'h2, 2'd1, 4'hD, 7'b0110000, 1'b0};
      vecs[6]  = '{16'hABCD, 4'h2, 2'd2, 4'hB, 7'b0100100, 1'b1};
      vecs[7]  = '{16'hABCD, 4'h2, 2'd3, 4'h7, 7'b1111001, 1'b1};
      vecs[8]  = '{16'hABCD, 4'h2, 2'd0, 4'hE, 7'b0100001, 1'b1};
      vecs[9]  = '{16'hABCD, 4'h2, 2'd1, 4'hD, 7'b1000110, 1'b0};
      vecs[10] = '{16'hABCD, 4'h2, 2'd2, 4'hB, 7'b0000011, 1'b1};
      vecs[11] = '{16'hABCD, 4'h2, 2'd3, 4'h7, 7'b0001000, 1'b1};
      vecs[12] = '{16'hF0E9, 4'h2, 2'd0, 4'hE, 7'b0010000, 1'b1};
      vecs[13] = '{16'hF0E9, 4'h9, 2'd1, 4'hD, 7'b0000110, 1'b0};
      vecs[14] = '{16'hF0E9, 4'h9, 2'd2, 4'hB, 7'b1000000, 1'b1};
      vecs[15] = '{16'hF0E9, 4'h9, 2'd3, 4'h7, 7'b0001110, 1'b1};
      vecs[16] = '{16'hF0E9, 4'h9, 2'd0, 4'hE, 7'b0010000, 1'b0};

      reset = 1'b1; scanClk = 1'b0; enable = 1'b1; value = 16'h1234; dp = 4'h2;
      @(posedge clk);
      @(posedge clk);
      #1;
      pushExp("reset", 2'd3, 4'hF, 7'h7F, 1'b1);
      checkOutput();

      @(negedge clk);
      reset = 1'b0;
      applyStimulus(16'h1234, 4'h2, 1'b0, 1'b1);
      pushExp("idleAfterReset", 2'd3, 4'hF, 7'h7F, 1'b1);
      checkOutput();

      // One tick per table row: expectation queued as the rising scan edge is driven.
      for (int i = 0; i < 17; i++) begin
         pushExp($sformatf("vec%0d", i), vecs[i].idx, vecs[i].an, vecs[i].seg, vecs[i].dpo);
         applyStimulus(vecs[i].value, vecs[i].dp, 1'b1, 1'b1);
         checkOutput();
         applyStimulus(vecs[i].value, vecs[i].dp, 1'b0, 1'b1);
      end

      pushExp("longHighFirst", 2'd1, 4'hD, 7'b0000110, 1'b1);
      applyStimulus(16'hF0E9, 4'h9, 1'b1, 1'b1);
      checkOutput();
      for (int c = 0; c < 49; c++) applyStimulus(16'hF0E9, 4'h9, 1'b1, 1'b1);
      pushExp("longHighEnd", 2'd1, 4'hD, 7'b0000110, 1'b1);
      checkOutput();
      applyStimulus(16'hF0E9, 4'h9, 1'b0, 1'b1);

      pushExp("toDigit2", 2'd2, 4'hB, 7'b1000000, 1'b1);
      applyStimulus(16'hF0E9, 4'h9, 1'b1, 1'b1);
      checkOutput();
      applyStimulus(16'hF0E9, 4'h9, 1'b0, 1'b1);

      pushExp("disableBlank", 2'd2, 4'hF, 7'h7F, 1'b1);
      applyStimulus(16'hF0E9, 4'h9, 1'b0, 1'b0);
      checkOutput();
      for (int t = 0; t < 3; t++) begin
         applyStimulus(16'hF0E9, 4'h9, 1'b1, 1'b0);
         applyStimulus(16'hF0E9, 4'h9, 1'b0, 1'b0);
      end
      pushExp("disabledTicks", 2'd2, 4'hF, 7'h7F, 1'b1);
      checkOutput();
      pushExp("reenableIdle", 2'd2, 4'hF, 7'h7F, 1'b1);
      applyStimulus(16'hF0E9, 4'h9, 1'b0, 1'b1);
      checkOutput();
      pushExp("reenableTick", 2'd3, 4'h7, 7'b0001110, 1'b0);
      applyStimulus(16'hF0E9, 4'h9, 1'b1, 1'b1);
      checkOutput();

      // Reset mid-scan with scanClk held high; the first edge after release must tick.
      @(negedge clk);
      reset = 1'b1;
      applyStimulus(16'h0050, 4'h0, 1'b1, 1'b1);
      pushExp("midScanReset", 2'd3, 4'hF, 7'h7F, 1'b1);
      checkOutput();
      @(negedge clk);
      reset = 1'b0;
      pushExp("tickAtReleaseDigit0", 2'd0, 4'hE, 7'b1000000, 1'b1);
      applyStimulus(16'h0050, 4'h0, 1'b1, 1'b1);
      checkOutput();
      applyStimulus(16'h0050, 4'h0, 1'b0, 1'b1);
      pushExp("lz.digit1", 2'd1, 4'hD, 7'b0010010, 1'b1);
      applyStimulus(16'h0050, 4'h0, 1'b1, 1'b1);
      checkOutput();
      applyStimulus(16'h0050, 4'h0, 1'b0, 1'b1);
`ifdef SEG_SCAN_LZB_EN
      pushExp("lz.digit2", 2'd2, 4'hF, 7'h7F, 1'b1);
`else
      pushExp("lz.digit2", 2'd2, 4'hB, 7'b1000000, 1'b1);
`endif
      applyStimulus(16'h0050, 4'h0, 1'b1, 1'b1);
      checkOutput();
      applyStimulus(16'h0050, 4'h0, 1'b0, 1'b1);
`ifdef SEG_SCAN_LZB_EN
      pushExp("lz.digit3", 2'd3, 4'hF, 7'h7F, 1'b1);
`else
      pushExp("lz.digit3", 2'd3, 4'h7, 7'b1000000, 1'b1);
`endif
      applyStimulus(16'h0050, 4'h0, 1'b1, 1'b1);
      checkOutput();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed driver for a 4-digit common-anode seven-segment display, directly downstream of the clock divider. It consumes the divider's slow square wave as its scan rate, converts each rising edge into a single-cycle strobe in the system clock domain, and on each strobe advances to the next digit. A 16-bit value is shown as four hex digits. The value is snapshotted once per full scan so a digit set never tears.

## Interface
- `ACTIVE_LOW`, default 1: when 1, `an`, `seg` and `dpOut` are driven active-low; when 0, they are active-high.
- `clk` input 1: system clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `scanClk` input 1: slow square wave from the clock divider; level only, never used as a clock.
- `enable` input 1: 1 enables scanning; 0 blanks the display.
- `value` input 16: hex value to display; `value[3:0]` is the rightmost digit.
- `dp` input 4: decimal-point request per digit; `dp[i]` belongs to digit i.
- `an` output 4: digit anode selects; one-hot when lit.
- `seg` output 7: segments as {g,f,e,d,c,b,a}.
- `dpOut` output 1: decimal-point segment.
- `digitIdx` output 2: index of the currently selected digit.

## Operation
- Edge detect:
  - `scanPrev` is a register that samples `scanClk` every cycle.
  - `tick = scanClk & ~scanPrev`, so there is exactly one tick per `scanClk` rising edge.
- Digit counter `idx` (2 bits):
  - On `tick & enable`, `idx <= idx + 1` and wraps from 3 to 0.
  - `digitIdx` = `idx`.
- Snapshot:
  - On a `tick & enable` where `idx == 3`, `snap <= value` and `snapDp <= dp`.
  - Digits shown during a scan always come from one snapshot.
- Output registers update on the same edge as `idx`, computed from the next `idx` and the next `snap`:
  - `an` is one-hot at bit `idx`.
  - `seg` is the hex decode of `snap[4*idx+3 -: 4]`.
  - `dpOut` = `snapDp[idx]`.
- Hex decode, full 0–F, active-high form, {g..a}:
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111
  - 4 = 1100110, 5 = 1101101, 6 = 1111101, 7 = 0000111
  - 8 = 1111111, 9 = 1101111, A = 1110111, b = 1111100
  - C = 0111001, d = 1011110, E = 1111001, F = 1110001
- Polarity: `ACTIVE_LOW = 1` inverts `an`, `seg` and `dpOut` at the output registers.
- Blank state: all anodes off, all segments off, dp off, each at its inactive level for the chosen polarity.
- Enable low:
  - The next edge drives the blank state.
  - `idx` and `snap` hold; ticks are ignored.
  - `scanPrev` keeps sampling `scanClk`.
- Enable returning high: the display stays blank until the next tick, which advances `idx` normally.
- Reset:
  - `idx = 3`, so the first tick wraps to digit 0 and loads a snapshot.
  - `scanPrev = 0`, `snap = 0`, `snapDp = 0`.
  - Outputs go to the blank state; `digitIdx = 3`.
- Simultaneous events:
  - `reset` overrides `tick` and `enable`.
  - `tick` with `enable = 0` has no effect.
  - A `value` change on a wrap edge is captured (`value` is sampled at that edge).
- Reset mid-scan: everything restarts from the reset state; there is no partial snapshot.

## Timing
- Latency:
  - `scanClk` sampled high at edge N with `scanPrev = 0` means `tick` is true during cycle N.
  - `idx`, `an`, `seg` and `dpOut` show the new digit after edge N; there is a single-edge response.
- If `scanClk` is high at the first edge after reset, a tick fires at that edge, because `scanPrev` resets to 0.
- Minimum `scanClk` high or low phase is 1 `clk` cycle. Each rising edge gives exactly one tick, regardless of how long the pulse lasts.
- A `value` update reaches the display within 4 ticks: it appears at the next wrap.
- Full refresh period: 4 `scanClk` periods.

## Configuration
- Macro `SEG_SCAN_LZB_EN` enables leading-zero blanking.
- When defined:
  - Digit i (i = 3..1) is blanked when `snap[15:4*i]` is all zero.
  - Blanking a digit forces its `an` bit off, its segments off and `dpOut` off.
  - `digitIdx` still advances.
  - Digit 0 is never blanked, so 0x0000 shows "0".
- When undefined: all four digits are always lit when enabled; 0x0000 shows "0000".

## Test plan
- Reset, `enable = 1`, `value = 16'h1234`, first `scanClk` rise → `digitIdx = 0`, `an = 4'b1110`, `seg = 7'b0011001` ("4", `ACTIVE_LOW = 1`) on the same edge as the tick.
- Four `scanClk` rises with `value = 16'h1234` → digits shown in order 4, 3, 2, 1; `an` steps 1110, 1101, 1011, 0111; then wraps to 1110.
- `scanClk` held high for 50 cycles → exactly one tick; `digitIdx` advances by 1 only.
- Change `value` from `16'h1234` to `16'hABCD` while `digitIdx = 1` → digits 2 and 3 still show "2" and "1"; after the wrap, digit 0 shows "d" (`seg = 7'b0100001` active-low).
- `enable = 0` mid-scan at `digitIdx = 2`, with 3 ticks → `an = 4'b1111`, `seg = 7'b1111111`, `digitIdx` stays 2. After `enable = 1` and the next tick, `digitIdx = 3`.
- With `SEG_SCAN_LZB_EN`, `value = 16'h0050`, full scan → digits 3 and 2 dark (`an` bit high); digit 1 shows "5" and digit 0 shows "0". Without the macro → "0050".
